// File: rtl/ym3438_write_sched.sv
// Host write scheduler: latches address/data writes from the host port and
// commits each accepted data write to the register file in the slot-0 phase-1
// window, holding the host-visible busy flag for a 31-slot guard interval.
module ym3438_write_sched (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       c1,
  input  logic       c2,
  input  logic       fsm_sel0,
  input  logic       wr,
  input  logic [1:0] a,
  input  logic [7:0] din,
  output logic [8:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       reg_wr,
  output logic       busy,
  output logic       drop
);

  localparam int unsigned CNT_W    = 5;
  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned DATA_W   = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(31);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    BUSY      = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_busy_cnt;
  logic [ADDR_W-1:0]  r_reg_addr;
  logic [DATA_W-1:0]  r_reg_data;
  logic               r_reg_wr;
  logic               r_busy;
  logic               r_drop;

  logic w_addr_wr;
  logic w_data_wr;
  logic w_addr_ok;
  logic w_data_ok;
  logic w_reject;
  logic w_commit;
  logic w_cnt_zero;

  // Write classification is always judged against the pre-edge state.
  assign w_addr_wr  = wr & ~a[0];
  assign w_data_wr  = wr &  a[0];
  assign w_cnt_zero = (r_busy_cnt == '0);
  assign w_addr_ok  = w_addr_wr & (r_state != WAIT_SLOT);
  assign w_data_ok  = w_data_wr & (r_state == IDLE);
  assign w_reject   = (w_addr_wr & ~w_addr_ok) | (w_data_wr & ~w_data_ok);

  // State register.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and commit decode.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_data_ok) w_state_nxt = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (c1 & fsm_sel0) begin
          w_commit    = 1'b1;
          w_state_nxt = w_cnt_zero ? IDLE : BUSY;
        end
      end
      BUSY: begin
        if (w_cnt_zero) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Guard counter: loaded on an accepted data write, counts slots down to zero.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      r_busy_cnt <= '0;
    end else if (w_data_ok) begin
      r_busy_cnt <= CNT_LOAD;
    end else if (c2 && !w_cnt_zero && (r_state != IDLE)) begin
      r_busy_cnt <= r_busy_cnt - CNT_W'(1);
    end
  end

  // Address/data latches and registered status outputs.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      r_reg_addr <= '0;
      r_reg_data <= '0;
      r_reg_wr   <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      if (w_addr_ok) r_reg_addr <= {a[1], din};
      if (w_data_ok) r_reg_data <= din;
      r_reg_wr <= w_commit;
      r_busy   <= (w_state_nxt != IDLE);
      r_drop   <= w_reject;
    end
  end

  assign reg_addr = r_reg_addr;
  assign reg_data = r_reg_data;
  assign reg_wr   = r_reg_wr;
  assign busy     = r_busy;
  assign drop     = r_drop;

endmodule

// File: tb/tb_ym3438_write_sched.sv
// Scoreboard bench for ym3438_write_sched: a flag-based behavioural model
// predicts commits and rejects, a negedge monitor compares the DUT against it.
module tb_ym3438_write_sched;

  logic       MCLK = 1'b0;
  logic       reset = 1'b1;
  logic       c1 = 1'b0;
  logic       c2 = 1'b0;
  logic       fsm_sel0 = 1'b0;
  logic       wr = 1'b0;
  logic [1:0] a = 2'b00;
  logic [7:0] din = 8'h00;
  logic [8:0] reg_addr;
  logic [7:0] reg_data;
  logic       reg_wr;
  logic       busy;
  logic       drop;

  ym3438_write_sched dut (
    .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .fsm_sel0(fsm_sel0),
    .wr(wr), .a(a), .din(din), .reg_addr(reg_addr), .reg_data(reg_data),
    .reg_wr(reg_wr), .busy(busy), .drop(drop)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    int         stamp;
    logic [8:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  wr_exp_t q_wr[$];
  int      q_drop[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: a write is "pending" until its slot-0 commit; the host
  // sees busy from acceptance until both the commit and the 31-slot guard end.
  bit         m_pending = 1'b0;
  bit         m_busy = 1'b0;
  int         m_cnt = 0;
  logic [8:0] m_addr = 9'h000;
  logic [7:0] m_data = 8'h00;

  // Slot timing: c1 and c2 alternate, one slot per c2, 24 slots per round.
  int ph = 0;
  int slot = 0;
  bit sel_force_low = 1'b0;

  task automatic model_clear();
    m_pending = 1'b0; m_busy = 1'b0; m_cnt = 0; m_addr = '0; m_data = '0;
    q_wr.delete();
    q_drop.delete();
  endtask

  task automatic model_step();
    bit         n_pending;
    bit         n_busy;
    int         n_cnt;
    logic [8:0] n_addr;
    logic [7:0] n_data;
    if (reset) return;
    n_pending = m_pending; n_busy = m_busy; n_cnt = m_cnt;
    n_addr = m_addr; n_data = m_data;
    if (wr && !a[0]) begin
      if (m_pending) q_drop.push_back(cyc + 1);
      else n_addr = {a[1], din};
    end
    if (wr && a[0]) begin
      if (m_busy) q_drop.push_back(cyc + 1);
      else begin
        n_data = din; n_cnt = 31; n_pending = 1'b1; n_busy = 1'b1;
      end
    end
    if (m_pending && c1 && fsm_sel0) begin
      q_wr.push_back('{cyc + 1, m_addr, m_data});
      n_pending = 1'b0;
      n_busy = (m_cnt != 0);
    end else if (m_busy && !m_pending && m_cnt == 0) begin
      n_busy = 1'b0;
    end
    if (c2 && m_busy && m_cnt > 0) n_cnt = m_cnt - 1;
    m_pending = n_pending; m_busy = n_busy; m_cnt = n_cnt;
    m_addr = n_addr; m_data = n_data;
  endtask

  // One MCLK cycle: drive inputs, advance the model on the edge.
  task automatic cycle(input bit w, input logic [1:0] aa, input logic [7:0] d);
    wr = w; a = aa; din = d;
    c1 = (ph == 0);
    c2 = (ph == 1);
    fsm_sel0 = sel_force_low ? 1'b0 : (slot == 0);
    @(posedge MCLK);
    model_step();
    cyc++;
    if (c2) slot = (slot + 1) % 24;
    ph = 1 - ph;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 8'h00);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    model_clear();
    idle(n);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && m_busy; i++) idle(1);
    checks++;
    if (m_busy) begin
      errors++;
      $display("FAIL %s: timeout, model still busy after 400 cycles", tag);
    end
  endtask

  // Monitor: pops expected events exactly when they are due.
  always @(negedge MCLK) begin
    bit      exp_wr;
    bit      exp_drop;
    wr_exp_t e;
    if (reset) begin
      checks++;
      if (reg_addr !== 9'h000 || reg_data !== 8'h00 || reg_wr !== 1'b0 ||
          busy !== 1'b0 || drop !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: addr=%h data=%h wr=%b busy=%b drop=%b, required all 0",
                 reg_addr, reg_data, reg_wr, busy, drop);
      end
    end else begin
      checks++;
      if (busy !== m_busy) begin
        errors++;
        $display("FAIL busy @%0d: got %b, required %b", cyc, busy, m_busy);
      end
      checks++;
      if (reg_addr !== m_addr) begin
        errors++;
        $display("FAIL reg_addr @%0d: got %h, required %h", cyc, reg_addr, m_addr);
      end
      checks++;
      if (reg_data !== m_data) begin
        errors++;
        $display("FAIL reg_data @%0d: got %h, required %h", cyc, reg_data, m_data);
      end
      exp_wr = (q_wr.size() > 0) && (q_wr[0].stamp == cyc);
      checks++;
      if (reg_wr !== exp_wr) begin
        errors++;
        $display("FAIL reg_wr @%0d: got %b, required %b", cyc, reg_wr, exp_wr);
      end
      if (exp_wr) begin
        e = q_wr.pop_front();
        checks++;
        if (reg_addr !== e.addr || reg_data !== e.data) begin
          errors++;
          $display("FAIL commit_payload @%0d: got %h/%h, required %h/%h",
                   cyc, reg_addr, reg_data, e.addr, e.data);
        end
      end
      exp_drop = (q_drop.size() > 0) && (q_drop[0] == cyc);
      checks++;
      if (drop !== exp_drop) begin
        errors++;
        $display("FAIL drop @%0d: got %b, required %b", cyc, drop, exp_drop);
      end
      if (exp_drop) void'(q_drop.pop_front());
    end
  end

  initial begin
    int guard;
    model_clear();
    do_reset(3);
    idle(2);

    // Address then data write; single commit in the next slot-0 window.
    cycle(1'b1, 2'b00, 8'h28);
    cycle(1'b1, 2'b01, 8'hF0);
    checks++;
    if (!(m_addr == 9'h028 && m_data == 8'hF0)) begin
      errors++;
      $display("FAIL basic_latch: model got %h/%h, required 028/F0", m_addr, m_data);
    end
    wait_idle("basic_commit");
    idle(3);

    // Rejections while pending, then an address write accepted in BUSY.
    cycle(1'b1, 2'b01, 8'h11);
    cycle(1'b1, 2'b10, 8'h30);
    cycle(1'b1, 2'b01, 8'h99);
    guard = 0;
    while (m_pending && guard < 200) begin idle(1); guard++; end
    checks++;
    if (m_pending) begin
      errors++;
      $display("FAIL busy_entry: timeout waiting for commit");
    end
    cycle(1'b1, 2'b10, 8'h30);
    cycle(1'b1, 2'b01, 8'h55);
    wait_idle("busy_addr");
    idle(2);

    // Slot-0 withheld for 40 slots: counter exhausts while waiting.
    sel_force_low = 1'b1;
    cycle(1'b1, 2'b01, 8'hA5);
    idle(80);
    checks++;
    if (!(m_pending && m_cnt == 0 && m_busy)) begin
      errors++;
      $display("FAIL long_wait: model pending=%b cnt=%0d, required 1 and 0", m_pending, m_cnt);
    end
    sel_force_low = 1'b0;
    wait_idle("long_wait_commit");
    idle(2);

    // Reset aborts a pending commit; next write accepted.
    cycle(1'b1, 2'b01, 8'h3C);
    idle(2);
    do_reset(2);
    idle(100);
    cycle(1'b1, 2'b01, 8'h7E);
    wait_idle("post_reset");
    idle(2);

    // Data write on the exact BUSY->IDLE edge is dropped; next one accepted.
    cycle(1'b1, 2'b01, 8'h42);
    guard = 0;
    while (!(m_busy && !m_pending && m_cnt == 0) && guard < 300) begin idle(1); guard++; end
    checks++;
    if (!(m_busy && !m_pending && m_cnt == 0)) begin
      errors++;
      $display("FAIL busy_exit: timeout waiting for BUSY exit cycle");
    end
    cycle(1'b1, 2'b01, 8'hE1);
    cycle(1'b1, 2'b01, 8'hE2);
    checks++;
    if (!(m_pending && m_data == 8'hE2)) begin
      errors++;
      $display("FAIL exit_rewrite: model data %h pending %b, required E2 and 1", m_data, m_pending);
    end
    wait_idle("exit_rewrite");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset(2);
      else if ($urandom_range(0, 5) == 0)
        cycle(1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      else
        idle(1);
    end
    wait_idle("random_drain");
    idle(5);
    checks++;
    if (q_wr.size() != 0 || q_drop.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: %0d commits and %0d drops outstanding, required 0",
               q_wr.size(), q_drop.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ym3438_write_sched.md
YM3438_WRITE_SCHED -- requirements
Module: ym3438_write_sched

Interface
REQ-001 SHALL provide: MCLK  input  1  sole clock; all state changes on posedge MCLK.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL provide: c1  input  1  phase-1 enable; one MCLK cycle wide; never high in the same cycle as c2.
REQ-004 SHALL provide: c2  input  1  phase-2 enable; one c2 cycle = one slot.
REQ-005 SHALL provide: fsm_sel0  input  1  sequencer slot-0 decode; marks the start of a 24-slot round.
REQ-006 SHALL provide: wr  input  1  host write strobe; one MCLK cycle per write.
REQ-007 SHALL provide: a  input  2  a[0]: 0 = address write, 1 = data write; a[1]: register bank.
REQ-008 SHALL provide: din  input  8  host write data.
REQ-009 SHALL provide: reg_addr  output  9  latched register address {bank, addr}.
REQ-010 SHALL provide: reg_data  output  8  latched register data.
REQ-011 SHALL provide: reg_wr  output  1  one-MCLK commit pulse to the register file.
REQ-012 SHALL provide: busy  output  1  host-visible busy flag.
REQ-013 SHALL provide: drop  output  1  one-MCLK pulse; a host write was rejected.

Function
REQ-014 SHALL implement three registered states: IDLE, WAIT_SLOT, BUSY.
REQ-015 SHALL set busy = (state != IDLE); busy is registered, with no combinational path from wr.
REQ-016 Address write (wr & ~a[0]) in IDLE or BUSY SHALL load reg_addr <= {a[1], din} on the next cycle; state is unchanged.
REQ-017 Address write in WAIT_SLOT SHALL be rejected: reg_addr is unchanged and drop pulses for one cycle.
REQ-018 Data write (wr & a[0]) in IDLE SHALL load reg_data <= din, load busy_cnt <= 31 and enter WAIT_SLOT.
REQ-019 Data write in WAIT_SLOT or BUSY SHALL be rejected: reg_data and busy_cnt are unchanged and drop pulses.
REQ-020 busy_cnt (5 bits) SHALL decrement by 1 on each c2 cycle while nonzero and the state is not IDLE; it saturates at 0 and never wraps.
REQ-021 In WAIT_SLOT, a cycle with c1 & fsm_sel0 SHALL pulse reg_wr for exactly one cycle on the next edge, with reg_addr and reg_data stable during that cycle.
REQ-022 On that same edge the state SHALL become BUSY if busy_cnt != 0, otherwise IDLE.
REQ-023 In BUSY, busy_cnt == 0 SHALL move the state to IDLE on the next edge.
REQ-024 In WAIT_SLOT with busy_cnt == 0, the block SHALL hold WAIT_SLOT until the commit of REQ-021; busy stays high.
REQ-025 A wr in the same cycle as the BUSY->IDLE transition SHALL be judged against the pre-edge state (BUSY): a data write is dropped, an address write is accepted.
REQ-026 A wr in the same cycle as the commit SHALL be judged against WAIT_SLOT and dropped, including address writes.
REQ-027 At most one reg_wr SHALL occur per accepted data write, and none without one.
REQ-028 c1 and c2 SHALL NOT both be high in the same cycle; this is not checked and behaviour is unspecified if violated.

Reset
REQ-029 While reset is high: state = IDLE, busy_cnt = 0, reg_addr = 0, reg_data = 0, reg_wr = 0, busy = 0, drop = 0.
REQ-030 Reset asserted in WAIT_SLOT or BUSY SHALL abort the pending commit; no reg_wr is emitted after release.
REQ-031 After reset release, the first wr SHALL be accepted normally.

Verification
REQ-032 Address write a=00, din=0x28, then data write a=01, din=0xF0 -> reg_addr=0x028, reg_data=0xF0; busy rises; exactly one reg_wr in the cycle after the next c1 & fsm_sel0.
REQ-033 Data write with c2 toggling every 2nd MCLK -> busy stays high for 31 c2 cycles after acceptance (plus commit wait if longer), then falls; a second data write during busy -> drop=1, reg_data unchanged.
REQ-034 Address write a=10, din=0x30 during WAIT_SLOT -> drop=1 and reg_addr unchanged; the same write during BUSY -> reg_addr=0x130.
REQ-035 fsm_sel0 held low for 40 slots after a data write -> busy_cnt=0, state stays WAIT_SLOT, no reg_wr; the first c1 & fsm_sel0 -> reg_wr, then IDLE on the next edge.
REQ-036 Reset pulsed 3 cycles after an accepted data write -> all outputs 0 immediately and no reg_wr ever appears; a data write after release is accepted.
REQ-037 Data write in the exact cycle of BUSY->IDLE -> drop=1; a data write in the following cycle is accepted.
